// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Buffered 8N1 UART transmitter. Bytes arrive over a valid/ready handshake,
// are queued in a small circular FIFO and are serialised LSB first on `tx`.
// Frames are sent back to back when more bytes are waiting, so the line only
// idles when the queue runs dry.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per UART bit (>= 2)
//   FIFO_DEPTH   : byte entries in the FIFO (power of two, >= 2)
//
// Ports
//   clk        : system clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   tx_data    : byte to queue, taken on a valid && ready edge
//   tx_valid   : tx_data holds a byte to queue
//   tx_ready   : FIFO can take a byte (!full && !rst, combinational)
//   tx         : serial line, idles high, registered
//   busy       : serialiser is framing a byte, registered
//   fifo_count : bytes waiting in the FIFO (excludes the byte being shifted)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 2604,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ZERO   = PTR_W'(0);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
   localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic [BAUD_W-1:0] BAUD_ONE   = BAUD_W'(1);
   localparam logic [BAUD_W-1:0] BAUD_ZERO  = BAUD_W'(0);
   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        BIT_LAST   = 3'd7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]        mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;

   // Serialiser state
   state_t            state_r;
   logic [BAUD_W-1:0] baud_r;
   logic [2:0]        bit_idx_r;
   logic [7:0]        shift_r;
   logic              tx_r;
   logic              busy_r;

   // Handshake / control decode
   logic              full_s;
   logic              empty_s;
   logic              push_s;
   logic              pop_s;
   logic              baud_last_s;
   logic [7:0]        head_s;

   assign full_s      = (count_r == FULL_COUNT);
   assign empty_s     = (count_r == CNT_ZERO);
   assign tx_ready    = !full_s && !rst;
   // tx_ready already folds in rst, so no byte can land on a reset edge.
   assign push_s      = tx_valid && tx_ready;
   assign baud_last_s = (baud_r == BAUD_LAST);
   assign head_s      = mem_r[rd_ptr_r];

   assign tx          = tx_r;
   assign busy        = busy_r;
   assign fifo_count  = count_r;

   // Pop decision: the serialiser takes the head byte when idle, or on the
   // final stop-bit cycle so the next start bit follows with no gap.
   always_comb begin
      pop_s = 1'b0;
      case (state_r)
         IDLE: begin
            pop_s = !empty_s;
         end
         STOP: begin
            if (baud_last_s) begin
               pop_s = !empty_s;
            end else begin
               pop_s = 1'b0;
            end
         end
         default: begin
            pop_s = 1'b0;
         end
      endcase
   end

   // FIFO pointers, occupancy count and storage writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= tx_data;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         // Simultaneous push and pop leave the occupancy unchanged.
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Frame serialiser FSM with registered line and busy outputs.
   // tx_r and busy_r are driven from the current state, so both trail the
   // state register by one cycle; the whole frame is shifted by that same
   // cycle, which keeps every symbol exactly CLKS_PER_BIT cycles long.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         baud_r    <= BAUD_ZERO;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
         tx_r      <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         busy_r <= (state_r != IDLE);
         case (state_r)
            IDLE: begin
               tx_r <= 1'b1;
               if (pop_s) begin
                  shift_r <= head_s;
                  baud_r  <= BAUD_ZERO;
                  state_r <= START;
               end else begin
                  baud_r  <= BAUD_ZERO;
                  state_r <= IDLE;
               end
            end
            START: begin
               tx_r <= 1'b0;
               if (baud_last_s) begin
                  baud_r    <= BAUD_ZERO;
                  bit_idx_r <= 3'd0;
                  state_r   <= DATA;
               end else begin
                  baud_r <= baud_r + BAUD_ONE;
               end
            end
            DATA: begin
               tx_r <= shift_r[0];
               if (baud_last_s) begin
                  baud_r  <= BAUD_ZERO;
                  shift_r <= {1'b0, shift_r[7:1]};
                  if (bit_idx_r == BIT_LAST) begin
                     bit_idx_r <= 3'd0;
                     state_r   <= STOP;
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                  end
               end else begin
                  baud_r <= baud_r + BAUD_ONE;
               end
            end
            STOP: begin
               tx_r <= 1'b1;
               if (baud_last_s) begin
                  baud_r <= BAUD_ZERO;
                  // pop_s is only true here when a byte is waiting.
                  if (pop_s) begin
                     shift_r <= head_s;
                     state_r <= START;
                  end else begin
                     state_r <= IDLE;
                  end
               end else begin
                  baud_r <= baud_r + BAUD_ONE;
               end
            end
            default: begin
               tx_r      <= 1'b1;
               baud_r    <= BAUD_ZERO;
               bit_idx_r <= 3'd0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule
